// File: rtl/wb_cdb_arbiter_if.sv
// Writeback/CDB bundle for wb_cdb_arbiter: N_SRC source result ports, flush request and the broadcast bus.
// The arbiter takes the slave view; execution units and ROB/PRF/RS take the master view.
package wb_cdb_pkg;
    localparam int ROB_W   = 6;
    localparam int PHYS_W  = 7;
    localparam int EPOCH_W = 2;
endpackage

interface wb_cdb_arbiter_if #(parameter int N_SRC = 3);
    import wb_cdb_pkg::*;

    logic [N_SRC-1:0]          src_valid;
    logic [N_SRC-1:0]          src_ready;
    logic [N_SRC*32-1:0]       src_pc;
    logic [N_SRC-1:0]          src_uses_rd;
    logic [N_SRC*ROB_W-1:0]    src_rob_idx;
    logic [N_SRC*PHYS_W-1:0]   src_prd_new;
    logic [N_SRC*EPOCH_W-1:0]  src_epoch;
    logic [N_SRC*32-1:0]       src_data;

    logic                      flush_valid;
    logic [EPOCH_W-1:0]        flush_epoch;

    logic                      cdb_valid;
    logic                      cdb_ready;
    logic [31:0]               cdb_pc;
    logic                      cdb_uses_rd;
    logic [ROB_W-1:0]          cdb_rob_idx;
    logic [PHYS_W-1:0]         cdb_prd_new;
    logic [EPOCH_W-1:0]        cdb_epoch;
    logic [31:0]               cdb_data;

    modport slave (
        input  src_valid, src_pc, src_uses_rd, src_rob_idx, src_prd_new, src_epoch, src_data,
        output src_ready,
        input  flush_valid, flush_epoch,
        output cdb_valid, cdb_pc, cdb_uses_rd, cdb_rob_idx, cdb_prd_new, cdb_epoch, cdb_data,
        input  cdb_ready
    );

    modport master (
        output src_valid, src_pc, src_uses_rd, src_rob_idx, src_prd_new, src_epoch, src_data,
        input  src_ready,
        output flush_valid, flush_epoch,
        input  cdb_valid, cdb_pc, cdb_uses_rd, cdb_rob_idx, cdb_prd_new, cdb_epoch, cdb_data,
        output cdb_ready
    );
endinterface

// File: rtl/wb_cdb_arbiter.sv
// Round-robin writeback arbiter into a registered CDB; squashed-epoch results are drained and dropped.
// Optional `WB_CDB_DROP_CNT_EN adds a saturating drop_cnt output counting discarded results.
module wb_cdb_arbiter
    import wb_cdb_pkg::*;
#(
    parameter int N_SRC = 3
) (
    input  logic clk,
    input  logic rst_n,
`ifdef WB_CDB_DROP_CNT_EN
    output logic [15:0] drop_cnt,
`endif
    wb_cdb_arbiter_if.slave bus
);

    localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [EPOCH_W-1:0] cur_epoch_q;
    logic [PTR_W-1:0]   rr_ptr_q;
    logic               out_vld_q;

    logic [N_SRC-1:0]   stale;
    logic [N_SRC-1:0]   live;
    logic               out_free;
    logic               grant_vld;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W:0]     idx_sum;
    logic [PTR_W-1:0]   rr_next;

    logic [31:0]        sel_pc;
    logic               sel_uses_rd;
    logic [ROB_W-1:0]   sel_rob_idx;
    logic [PHYS_W-1:0]  sel_prd_new;
    logic [EPOCH_W-1:0] sel_epoch;
    logic [31:0]        sel_data;

    always_comb begin
        stale = '0;
        live  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            stale[i] = bus.src_valid[i] && (bus.src_epoch[i*EPOCH_W +: EPOCH_W] != cur_epoch_q);
            live[i]  = bus.src_valid[i] && !stale[i];
        end
    end

    // Search starts at the round-robin pointer; sum is one bit wider so the wrap is a single subtract.
    always_comb begin
        out_free  = !out_vld_q || bus.cdb_ready;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx_sum   = '0;
        if (out_free && !bus.flush_valid) begin
            for (int k = 0; k < N_SRC; k++) begin
                idx_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
                if (idx_sum >= (PTR_W+1)'(N_SRC))
                    idx_sum = idx_sum - (PTR_W+1)'(N_SRC);
                if (!grant_vld && live[idx_sum[PTR_W-1:0]]) begin
                    grant_vld = 1'b1;
                    grant_idx = idx_sum[PTR_W-1:0];
                end
            end
        end
    end

    assign rr_next = (grant_idx == PTR_W'(N_SRC-1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        sel_pc      = '0;
        sel_uses_rd = 1'b0;
        sel_rob_idx = '0;
        sel_prd_new = '0;
        sel_epoch   = '0;
        sel_data    = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                sel_pc      = bus.src_pc[i*32 +: 32];
                sel_uses_rd = bus.src_uses_rd[i];
                sel_rob_idx = bus.src_rob_idx[i*ROB_W +: ROB_W];
                sel_prd_new = bus.src_prd_new[i*PHYS_W +: PHYS_W];
                sel_epoch   = bus.src_epoch[i*EPOCH_W +: EPOCH_W];
                sel_data    = bus.src_data[i*32 +: 32];
            end
        end
    end

    // Stale results are accepted unconditionally so a squashed unit never blocks behind the CDB.
    always_comb begin
        bus.src_ready = '0;
        if (rst_n && !bus.flush_valid) begin
            bus.src_ready = stale;
            if (grant_vld)
                bus.src_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_epoch_q     <= '0;
            rr_ptr_q        <= '0;
            out_vld_q       <= 1'b0;
            bus.cdb_pc      <= '0;
            bus.cdb_uses_rd <= 1'b0;
            bus.cdb_rob_idx <= '0;
            bus.cdb_prd_new <= '0;
            bus.cdb_epoch   <= '0;
            bus.cdb_data    <= '0;
        end else if (bus.flush_valid) begin
            cur_epoch_q <= bus.flush_epoch;
            out_vld_q   <= 1'b0;
        end else if (grant_vld) begin
            out_vld_q       <= 1'b1;
            rr_ptr_q        <= rr_next;
            bus.cdb_pc      <= sel_pc;
            bus.cdb_uses_rd <= sel_uses_rd;
            bus.cdb_rob_idx <= sel_rob_idx;
            bus.cdb_prd_new <= sel_prd_new;
            bus.cdb_epoch   <= sel_epoch;
            bus.cdb_data    <= sel_data;
        end else if (bus.cdb_ready) begin
            out_vld_q <= 1'b0;
        end
    end

    assign bus.cdb_valid = out_vld_q;

`ifdef WB_CDB_DROP_CNT_EN
    logic [PTR_W:0] drop_inc;
    logic [16:0]    drop_sum;

    // A flush drops at most the held entry; stale handshakes cannot happen in a flush cycle.
    always_comb begin
        drop_inc = '0;
        if (bus.flush_valid) begin
            drop_inc = {{PTR_W{1'b0}}, out_vld_q};
        end else begin
            for (int i = 0; i < N_SRC; i++)
                drop_inc = drop_inc + {{PTR_W{1'b0}}, stale[i]};
        end
        drop_sum = {1'b0, drop_cnt} + 17'(drop_inc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_cnt <= '0;
        else
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
`endif

endmodule

// File: tb/tb_wb_cdb_arbiter.sv
// Self-checking bench for wb_cdb_arbiter: directed vectors, a per-cycle reference model and literal pins.
// Build with +define+WB_CDB_DROP_CNT_EN to also check drop_cnt.
module tb_wb_cdb_arbiter;
    import wb_cdb_pkg::*;

    localparam int N_SRC = 3;
    localparam int PAY_W = 32 + 1 + ROB_W + PHYS_W + EPOCH_W + 32;

    logic clk;
    logic rst_n;
`ifdef WB_CDB_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int errors = 0;
    int checks = 0;

    wb_cdb_arbiter_if #(.N_SRC(N_SRC)) bus ();

    wb_cdb_arbiter #(.N_SRC(N_SRC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef WB_CDB_DROP_CNT_EN
        .drop_cnt (drop_cnt),
`endif
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: what the arbiter's output register, epoch, pointer and counter must hold.
    logic               m_vld;
    logic [PAY_W-1:0]   m_pay;
    logic [EPOCH_W-1:0] m_epoch;
    int                 m_rr;
    int                 m_drop;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic setSrc(input int i, input bit v, input int rob, input int ep, input logic [31:0] data);
        bus.src_valid[i]                  = v;
        bus.src_pc[i*32 +: 32]            = 32'h1000 + 32'(rob * 4);
        bus.src_uses_rd[i]                = rob[0];
        bus.src_rob_idx[i*ROB_W +: ROB_W] = ROB_W'(rob);
        bus.src_prd_new[i*PHYS_W +: PHYS_W] = PHYS_W'(rob + 3);
        bus.src_epoch[i*EPOCH_W +: EPOCH_W] = EPOCH_W'(ep);
        bus.src_data[i*32 +: 32]          = data;
    endtask

    task automatic applyStimulus(input bit cdb_rdy, input bit flush, input int f_ep);
        @(posedge clk);
        #1;
        bus.cdb_ready   = cdb_rdy;
        bus.flush_valid = flush;
        bus.flush_epoch = EPOCH_W'(f_ep);
        bus.src_valid   = '0;
    endtask

    function automatic logic [PAY_W-1:0] srcPayload(input int i);
        return {bus.src_pc[i*32 +: 32], bus.src_uses_rd[i], bus.src_rob_idx[i*ROB_W +: ROB_W],
                bus.src_prd_new[i*PHYS_W +: PHYS_W], bus.src_epoch[i*EPOCH_W +: EPOCH_W],
                bus.src_data[i*32 +: 32]};
    endfunction

    // Compare process: at each falling edge the DUT registers reflect the last rising edge and the
    // inputs are those the next rising edge will sample, so check then advance the model.
    always @(negedge clk) begin : compare
        logic [N_SRC-1:0] exp_ready;
        logic [PAY_W-1:0] dut_pay;
        int g;
        int n_stale;
        int idx;
        if (!rst_n) begin
            m_vld = 1'b0; m_pay = '0; m_epoch = '0; m_rr = 0; m_drop = 0;
            checkOutput("rst_cdb_valid", 128'(bus.cdb_valid), 128'(0));
            checkOutput("rst_src_ready", 128'(bus.src_ready), 128'(0));
        end else begin
            dut_pay = {bus.cdb_pc, bus.cdb_uses_rd, bus.cdb_rob_idx, bus.cdb_prd_new, bus.cdb_epoch, bus.cdb_data};
            checkOutput("cdb_valid", 128'(bus.cdb_valid), 128'(m_vld));
            if (m_vld)
                checkOutput("cdb_payload", 128'(dut_pay), 128'(m_pay));
`ifdef WB_CDB_DROP_CNT_EN
            checkOutput("drop_cnt", 128'(drop_cnt), 128'(m_drop));
`endif
            exp_ready = '0;
            g = -1;
            n_stale = 0;
            if (!bus.flush_valid) begin
                for (int i = 0; i < N_SRC; i++)
                    if (bus.src_valid[i] && bus.src_epoch[i*EPOCH_W +: EPOCH_W] != m_epoch) begin
                        exp_ready[i] = 1'b1;
                        n_stale++;
                    end
                if (!m_vld || bus.cdb_ready)
                    for (int k = 0; k < N_SRC; k++) begin
                        idx = (m_rr + k) % N_SRC;
                        if (g < 0 && bus.src_valid[idx] && bus.src_epoch[idx*EPOCH_W +: EPOCH_W] == m_epoch)
                            g = idx;
                    end
                if (g >= 0)
                    exp_ready[g] = 1'b1;
            end
            checkOutput("src_ready", 128'(bus.src_ready), 128'(exp_ready));

            if (bus.flush_valid) begin
                m_drop  = m_drop + int'(m_vld);
                m_vld   = 1'b0;
                m_epoch = bus.flush_epoch;
            end else begin
                m_drop = m_drop + n_stale;
                if (g >= 0) begin
                    m_vld = 1'b1;
                    m_pay = srcPayload(g);
                    m_rr  = (g + 1) % N_SRC;
                end else if (bus.cdb_ready) begin
                    m_vld = 1'b0;
                end
            end
            if (m_drop > 65535)
                m_drop = 65535;
        end
    end

    initial begin
        rst_n = 1'b0;
        bus.cdb_ready = 1'b0; bus.flush_valid = 1'b0; bus.flush_epoch = '0;
        bus.src_valid = '0; bus.src_pc = '0; bus.src_uses_rd = '0; bus.src_rob_idx = '0;
        bus.src_prd_new = '0; bus.src_epoch = '0; bus.src_data = '0;
        setSrc(0, 1, 1, 0, 32'h1);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_src_ready", 128'(bus.src_ready), 128'(0));
        checkOutput("reset_cdb_valid", 128'(bus.cdb_valid), 128'(0));
        checkOutput("reset_cdb_data", 128'(bus.cdb_data), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.src_valid = '0;

        // Fairness: all three sources always live, grants rotate 0,1,2,0,1,2.
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1, 0, 0);
            for (int i = 0; i < N_SRC; i++) setSrc(i, 1, 10 + i, 0, 32'hA000_0000 + 32'(k * 16 + i));
            #2;
            checkOutput("fair_ready", 128'(bus.src_ready), 128'(1 << (k % 3)));
            if (k > 0) begin
                checkOutput("fair_valid", 128'(bus.cdb_valid), 128'(1));
                checkOutput("fair_rob", 128'(bus.cdb_rob_idx), 128'(10 + ((k - 1) % 3)));
            end
        end

        // Single live result on src 0, visible one cycle later.
        applyStimulus(1, 0, 0);
        setSrc(0, 1, 5, 0, 32'hDEADBEEF);
        #2;
        checkOutput("single_ready", 128'(bus.src_ready), 128'(3'b001));
        checkOutput("fair_last_rob", 128'(bus.cdb_rob_idx), 128'(12));
        applyStimulus(1, 0, 0);
        #2;
        checkOutput("single_valid", 128'(bus.cdb_valid), 128'(1));
        checkOutput("single_rob", 128'(bus.cdb_rob_idx), 128'(5));
        checkOutput("single_data", 128'(bus.cdb_data), 128'(32'hDEADBEEF));

        // Backpressure: rob 20 held four cycles while src 1 waits.
        applyStimulus(1, 0, 0);
        setSrc(0, 1, 20, 0, 32'h2020);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 0, 0);
            setSrc(1, 1, 21, 0, 32'h2121);
            #2;
            checkOutput("bp_ready", 128'(bus.src_ready), 128'(0));
            checkOutput("bp_rob", 128'(bus.cdb_rob_idx), 128'(20));
            checkOutput("bp_data", 128'(bus.cdb_data), 128'(32'h2020));
        end
        applyStimulus(1, 0, 0);
        setSrc(1, 1, 21, 0, 32'h2121);
        #2;
        checkOutput("bp_release_ready", 128'(bus.src_ready), 128'(3'b010));
        applyStimulus(1, 0, 0);
        #2;
        checkOutput("bp_next_rob", 128'(bus.cdb_rob_idx), 128'(21));

        // Flush kills held rob 7; old-epoch src 2 drains, new-epoch src 0 is broadcast.
        applyStimulus(0, 0, 0);
        setSrc(2, 1, 7, 0, 32'h0707);
        #2;
        checkOutput("flush_pre_ready", 128'(bus.src_ready), 128'(3'b100));
        applyStimulus(1, 1, 1);
        setSrc(2, 1, 8, 0, 32'h0808);
        #2;
        checkOutput("flush_ready", 128'(bus.src_ready), 128'(0));
        checkOutput("flush_held_rob", 128'(bus.cdb_rob_idx), 128'(7));
        applyStimulus(1, 0, 0);
        setSrc(2, 1, 8, 0, 32'h0808);
        setSrc(0, 1, 9, 1, 32'h0909);
        #2;
        checkOutput("flush_after_valid", 128'(bus.cdb_valid), 128'(0));
        checkOutput("flush_drain_ready", 128'(bus.src_ready), 128'(3'b101));
        applyStimulus(1, 0, 0);
        #2;
        checkOutput("flush_new_rob", 128'(bus.cdb_rob_idx), 128'(9));

        // Stale drain alongside a live grant.
        applyStimulus(1, 0, 0);
        setSrc(0, 1, 30, 0, 32'h3030);
        setSrc(1, 1, 31, 1, 32'h3131);
        #2;
        checkOutput("stale_live_ready", 128'(bus.src_ready), 128'(3'b011));
        applyStimulus(1, 0, 0);
        #2;
        checkOutput("stale_live_rob", 128'(bus.cdb_rob_idx), 128'(31));
`ifdef WB_CDB_DROP_CNT_EN
        checkOutput("drop_literal", 128'(drop_cnt), 128'(3));
`endif

        // Mixed traffic: stalls, stale/live mixes and periodic flushes, checked by the model.
        for (int k = 0; k < 24; k++) begin
            applyStimulus((k % 3) != 0, (k % 7) == 6, k / 7);
            for (int i = 0; i < N_SRC; i++)
                setSrc(i, ((k + i) % 4) != 0, 50 + k * 3 + i,
                       ((k + i) % 3 == 0) ? int'(m_epoch) + 1 : int'(m_epoch), 32'(k * 256 + i));
        end

        // Asynchronous reset while an entry is held.
        applyStimulus(1, 1, 2);
        applyStimulus(1, 0, 0);
        setSrc(0, 1, 40, 2, 32'h4040);
        applyStimulus(0, 0, 0);
        #2;
        checkOutput("pre_reset_valid", 128'(bus.cdb_valid), 128'(1));
        checkOutput("pre_reset_rob", 128'(bus.cdb_rob_idx), 128'(40));
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_valid", 128'(bus.cdb_valid), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        applyStimulus(1, 0, 0);
        setSrc(0, 1, 41, 0, 32'h4141);
        setSrc(1, 1, 42, 0, 32'h4242);
        #2;
        checkOutput("post_reset_ready", 128'(bus.src_ready), 128'(3'b001));
        applyStimulus(1, 0, 0);
        #2;
        checkOutput("post_reset_rob", 128'(bus.cdb_rob_idx), 128'(41));
        applyStimulus(1, 0, 0);
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
